prio_req_encoder: RTL and testbench
===================================

# prio_req_encoder

Parametrised, registered N-to-log2(N) priority encoder with pending-request latching, per-line masking and a valid/ack handshake. It is the sequential successor to the combinational 4-to-2 priority encoder: request lines are captured into a pending register, the winning index is presented and held until the consumer acknowledges, then that request is retired. It sits between raw request/interrupt sources and a single sequential consumer, such as a controller FSM or an interrupt service unit.

## Interface
- N, default 8: number of request lines, 2..64.
- RR_MODE, default 0: 0 selects fixed priority with the highest index winning; 1 selects round-robin.
- EDGE_MODE, default 1: 1 latches rising edges of `req`; 0 latches levels.
- W: localparam, $clog2(N); not overridable.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  capture/select enable; when low, no new captures or selections occur.
- req  in  N  request lines.
- mask  in  N  1 = line eligible for selection; pending bits are captured regardless of mask.
- ack  in  1  consumer accepts the presented index; meaningful only while `valid` = 1.
- valid  out  1  `idx` holds a valid grant.
- idx  out  W  granted request index; 0 when `valid` = 0.
- pend  out  N  current pending register, for status.

## Operation
- Capture, applied every cycle while `en` = 1:
  - EDGE_MODE = 1: pend |= req & ~req_q, where `req_q` is `req` registered every cycle regardless of `en`.
  - EDGE_MODE = 0: pend |= req.
- Eligible vector: elig = pend & mask.
- Fixed priority: winner is the highest set bit of `elig`.
- Round-robin: search upward from ptr+1, wrapping modulo N; the first set bit wins. `ptr` is updated to the granted index on accept.
- FSM IDLE:
  - Stays in IDLE while `en` = 0 or `elig` = 0.
  - Otherwise registers the winner into `idx`, sets `valid`, and moves to HOLD.
- FSM HOLD:
  - `idx` and `valid` are frozen; later changes to `mask`, `req` or `en` never retract or alter them.
  - On `ack` = 1: clear pend[idx], update `ptr` (RR_MODE only), clear `valid`, force `idx` to 0, return to IDLE.
- Clear and capture of the same bit in the same cycle: capture wins and the bit stays pending.
- `ack` while `valid` = 0 is ignored.
- `en` low in HOLD does not block completion; the handshake still finishes on `ack`.
- Reset values: pend = 0, req_q = 0, valid = 0, idx = 0, ptr = N-1 (so the first round-robin search starts at bit 0), FSM = IDLE.
- Reset asserted mid-HOLD drops `valid` immediately (asynchronously) and discards all pending requests.

## Timing
- Latency: a request edge sampled at clock edge k sets `pend` after edge k; `valid` and `idx` are asserted after edge k+1 (2-cycle latency).
- Ack sampled high at edge m: `valid` = 0 after edge m; the next grant appears no earlier than after edge m+1.
- Maximum throughput is one grant per 2 cycles.
- Level mode: a line held high is recaptured in the same cycle it is cleared, so it re-grants continuously. This is intended behaviour.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `prio_enc_pkg` holds:
  - the FSM state typedef (IDLE, HOLD);
  - a constant function `clog2_min1` so that the index width is at least 1.
- Sub-module `prio_pick`: combinational highest-set-bit finder (N in; index and found flag out).
  - Fixed priority uses it directly.
  - Round-robin rotates `elig` by ptr+1, feeds `prio_pick`, then un-rotates the index modulo N.
- Top level holds the capture logic, `req_q`, `pend`, `ptr` and the FSM.

## Test plan
- Reset/basic (N=8, fixed priority, edge mode): req=8'b0010_0100 pulsed for 1 cycle, mask all 1s -> valid after 2 edges with idx=5. Ack -> next grant idx=2. Ack -> valid stays 0, pend=0.
- Masking: pend=8'b1000_0001, mask=8'b0111_1111 -> idx=0. Set mask[7] while in HOLD -> idx stays 0 until ack, then idx=7.
- Round-robin (RR_MODE=1, level mode): req=8'b1000_1001 held, ack every grant -> idx sequence 0, 3, 7, 0, 3, 7, ...
- Simultaneous clear and capture: edge mode, new rising edge on req[4] in the same cycle as ack of idx=4 -> pend[4] remains 1 and idx=4 is granted again.
- Enable and reset: en=0 with a req pulse -> no capture and valid stays 0. Separately, assert rst_n low in HOLD -> valid=0, idx=0, pend=0 immediately, without waiting for a clock edge.
- Width sweep: N=2 and N=64 -> highest-bit winner is correct, idx width matches W, and round-robin wraps from N-1 to 0.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// ============================================================================
// prio_enc_pkg
//   Shared FSM state type and width helper for the priority request encoder.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package prio_enc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Index width, never below one bit so that an N=1-style corner still has a port.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_pick.sv
// ============================================================================
// prio_pick
//   Combinational highest-set-bit finder: returns the index and a found flag.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module prio_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prio_req_encoder.sv
// ============================================================================
// prio_req_encoder
//   Registered N-to-log2(N) priority encoder with pending latch, mask and
//   valid/ack handshake; fixed or round-robin arbitration.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module prio_req_encoder
    import prio_enc_pkg::*;
#(
    parameter  int N         = 8,
    parameter  int RR_MODE   = 0,
    parameter  int EDGE_MODE = 1,
    localparam int W         = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] pend
);

    state_t         r_state;
    state_t         w_state_d;
    logic [W-1:0]   r_idx;
    logic [W-1:0]   w_idx_d;
    logic [N-1:0]   r_pend;
    logic [N-1:0]   w_pend_d;
    logic [N-1:0]   w_rise;
    logic [N-1:0]   w_cap;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_elig;
    logic [W-1:0]   w_win;
    logic           w_found;
    logic           w_accept;

    // ---------------- capture ----------------
    if (EDGE_MODE != 0) begin : g_edge
        logic [N-1:0] r_req_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_req_q <= '0;
            end else begin
                r_req_q <= req;
            end
        end

        assign w_rise = req & ~r_req_q;
    end else begin : g_level
        assign w_rise = req;
    end

    assign w_cap    = en ? w_rise : '0;
    assign w_clr    = w_accept ? (N'(1) << r_idx) : '0;
    // Capture is OR-ed in after the clear, so a same-cycle re-request survives.
    assign w_pend_d = (r_pend & ~w_clr) | w_cap;
    assign w_elig   = r_pend & mask;

    // ---------------- winner selection ----------------
    if (RR_MODE != 0) begin : g_rr
        logic [W-1:0] r_ptr;
        logic [W:0]   w_sh;
        logic [N-1:0] w_rot;
        logic [N-1:0] w_rev;
        logic [W-1:0] w_p;
        logic [W:0]   w_sum;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ptr <= W'(N - 1);
            end else if (w_accept) begin
                r_ptr <= r_idx;
            end
        end

        // Rotate so bit ptr+1 lands at 0, then reverse so the lowest rotated
        // bit becomes the highest, which the highest-bit finder picks.
        assign w_sh  = {1'b0, r_ptr} + (W+1)'(1);
        assign w_rot = N'({w_elig, w_elig} >> w_sh);

        for (genvar j = 0; j < N; j++) begin : g_rev
            assign w_rev[N-1-j] = w_rot[j];
        end

        prio_pick #(
            .N (N),
            .W (W)
        ) u_pick (
            .vec   (w_rev),
            .idx   (w_p),
            .found (w_found)
        );

        // Rotated offset is N-1-p; absolute index is (ptr + N - p) mod N.
        always_comb begin
            w_sum = {1'b0, r_ptr} + (W+1)'(N) - {1'b0, w_p};
            if (w_sum >= (W+1)'(N)) begin
                w_sum = w_sum - (W+1)'(N);
            end
        end

        assign w_win = W'(w_sum);
    end else begin : g_fixed
        prio_pick #(
            .N (N),
            .W (W)
        ) u_pick (
            .vec   (w_elig),
            .idx   (w_win),
            .found (w_found)
        );
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_pend  <= w_pend_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && w_found) begin
                    w_idx_d   = w_win;
                    w_state_d = HOLD;
                end
            end
            HOLD: begin
                // Completion ignores en so a stalled source cannot wedge the consumer.
                if (ack) begin
                    w_accept  = 1'b1;
                    w_idx_d   = '0;
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    assign valid = (r_state == HOLD);
    assign idx   = r_idx;
    assign pend  = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_prio_req_encoder.sv
// ============================================================================
// tb_prio_req_encoder
//   Scoreboard bench: five encoder configurations, directed request patterns.
//   Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prio_req_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // A: N=8 fixed edge, B: N=8 RR level, C: N=2 fixed edge,
    // D: N=64 RR edge, E: N=64 fixed edge
    logic        en_a, ack_a, valid_a;
    logic [7:0]  req_a, mask_a, pend_a;
    logic [2:0]  idx_a;
    logic        en_b, ack_b, valid_b;
    logic [7:0]  req_b, pend_b;
    logic [7:0]  mask_b = 8'hFF;
    logic [2:0]  idx_b;
    logic        en_cde = 1'b1;
    logic        ack_c = 1'b0, valid_c;
    logic [1:0]  req_c, pend_c;
    logic [1:0]  mask_c = 2'b11;
    logic [0:0]  idx_c;
    logic        ack_d = 1'b0, valid_d, ack_e = 1'b0, valid_e;
    logic [63:0] req_d, pend_d, req_e, pend_e;
    logic [63:0] mask_de = '1;
    logic [5:0]  idx_d, idx_e;

    prio_req_encoder #(.N(8), .RR_MODE(0), .EDGE_MODE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .req(req_a), .mask(mask_a),
        .ack(ack_a), .valid(valid_a), .idx(idx_a), .pend(pend_a));
    prio_req_encoder #(.N(8), .RR_MODE(1), .EDGE_MODE(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .req(req_b), .mask(mask_b),
        .ack(ack_b), .valid(valid_b), .idx(idx_b), .pend(pend_b));
    prio_req_encoder #(.N(2), .RR_MODE(0), .EDGE_MODE(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .en(en_cde), .req(req_c), .mask(mask_c),
        .ack(ack_c), .valid(valid_c), .idx(idx_c), .pend(pend_c));
    prio_req_encoder #(.N(64), .RR_MODE(1), .EDGE_MODE(1)) u_dut_d (
        .clk(clk), .rst_n(rst_n), .en(en_cde), .req(req_d), .mask(mask_de),
        .ack(ack_d), .valid(valid_d), .idx(idx_d), .pend(pend_d));
    prio_req_encoder #(.N(64), .RR_MODE(0), .EDGE_MODE(1)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .en(en_cde), .req(req_e), .mask(mask_de),
        .ack(ack_e), .valid(valid_e), .idx(idx_e), .pend(pend_e));

    int n_tests = 0;
    int n_fail  = 0;

    logic        vld  [5];
    logic [63:0] gidx [5];
    logic        prev_v [5] = '{default: 1'b0};
    int unsigned exp_q [5][$];
    int unsigned mon_e;

    assign vld[0] = valid_a;  assign gidx[0] = 64'(idx_a);
    assign vld[1] = valid_b;  assign gidx[1] = 64'(idx_b);
    assign vld[2] = valid_c;  assign gidx[2] = 64'(idx_c);
    assign vld[3] = valid_d;  assign gidx[3] = 64'(idx_d);
    assign vld[4] = valid_e;  assign gidx[4] = 64'(idx_e);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every new grant is matched against the head of its queue.
    always @(negedge clk) begin
        for (int d = 0; d < 5; d++) begin
            if (rst_n && vld[d] && !prev_v[d]) begin
                if (exp_q[d].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL grant_unexpected dut%0d: got idx %0d, expected no grant", d, gidx[d]);
                end else begin
                    mon_e = exp_q[d].pop_front();
                    check($sformatf("grant_dut%0d", d), gidx[d], 64'(mon_e));
                end
            end
            prev_v[d] = rst_n && vld[d];
        end
    end

    // Consumers for C/D/E accept each grant one cycle after it appears.
    initial begin
        forever begin
            @(negedge clk);
            ack_c = valid_c;
            ack_d = valid_d;
            ack_e = valid_e;
        end
    end

    task automatic ack_a_pulse();
        int i;
        i = 0;
        while (!valid_a && i < 20) begin
            tick();
            i++;
        end
        if (!valid_a) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_wait_a: got valid 0, expected valid 1 within 20 cycles");
        end else begin
            ack_a = 1'b1;
            tick();
            ack_a = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish by 100us");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        en_a = 1'b1; ack_a = 1'b0; req_a = '0; mask_a = 8'hFF;
        en_b = 1'b1; ack_b = 1'b0; req_b = '0;
        req_c = '0; req_d = '0; req_e = '0;
        tick(); tick();
        check("reset_valid", 64'(valid_a), 64'd0);
        check("reset_idx",   64'(idx_a),   64'd0);
        check("reset_pend",  64'(pend_a),  64'd0);
        rst_n = 1'b1;
        tick();

        // Width sweep: both-line pulses, highest first (fixed) / upward (RR).
        req_c = 2'b11;
        req_d = (64'd1 << 63) | (64'd1 << 5);
        req_e = (64'd1 << 63) | (64'd1 << 1);
        exp_q[2].push_back(1);  exp_q[2].push_back(0);
        exp_q[3].push_back(5);  exp_q[3].push_back(63);
        exp_q[4].push_back(63); exp_q[4].push_back(1);

        // Basic: 0010_0100 pulse -> 5 then 2, two-edge latency.
        req_a = 8'h24;
        exp_q[0].push_back(5); exp_q[0].push_back(2);
        tick();
        req_a = '0; req_c = '0; req_d = '0; req_e = '0;
        check("basic_pend_after_1",  64'(pend_a),  64'h24);
        check("basic_valid_after_1", 64'(valid_a), 64'd0);
        tick();
        check("basic_valid_after_2", 64'(valid_a), 64'd1);
        ack_a_pulse();
        check("ack_drops_valid", 64'(valid_a), 64'd0);
        check("ack_zeroes_idx",  64'(idx_a),   64'd0);
        ack_a_pulse();
        tick(); tick();
        check("basic_done_valid", 64'(valid_a), 64'd0);
        check("basic_done_pend",  64'(pend_a),  64'd0);

        // RR wrap on N=64: ptr now 63, search starts at 0 -> 1 before 62.
        req_d = (64'd1 << 62) | (64'd1 << 1);
        exp_q[3].push_back(1); exp_q[3].push_back(62);
        tick();
        req_d = '0;

        // Masking: line 7 masked, then unmasked while holding idx 0.
        mask_a = 8'h7F;
        req_a  = 8'h81;
        exp_q[0].push_back(0); exp_q[0].push_back(7);
        tick();
        req_a = '0;
        tick();
        mask_a = 8'hFF;
        tick(); tick();
        check("hold_valid", 64'(valid_a), 64'd1);
        check("hold_idx",   64'(idx_a),   64'd0);
        ack_a_pulse();
        ack_a_pulse();
        tick();

        // Same-cycle clear and recapture of line 4.
        req_a = 8'h10;
        exp_q[0].push_back(4); exp_q[0].push_back(4);
        tick();
        req_a = '0;
        tick();
        req_a = 8'h10;
        ack_a = 1'b1;
        tick();
        req_a = '0;
        ack_a = 1'b0;
        check("clr_vs_cap_pend",  64'(pend_a),  64'h10);
        check("clr_vs_cap_valid", 64'(valid_a), 64'd0);
        ack_a_pulse();
        tick();
        check("clr_vs_cap_done", 64'(pend_a), 64'd0);

        // Enable low: pulse must not be captured.
        en_a  = 1'b0;
        req_a = 8'h08;
        tick();
        req_a = '0;
        tick(); tick();
        check("en_low_pend",  64'(pend_a),  64'd0);
        check("en_low_valid", 64'(valid_a), 64'd0);
        en_a = 1'b1;
        tick(); tick(); tick();
        check("en_back_valid", 64'(valid_a), 64'd0);

        // Round-robin, level mode: 1000_1001 held -> 0,3,7,0,3,7.
        req_b = 8'h89;
        exp_q[1].push_back(0); exp_q[1].push_back(3); exp_q[1].push_back(7);
        exp_q[1].push_back(0); exp_q[1].push_back(3); exp_q[1].push_back(7);
        for (int g = 0; g < 6; g++) begin
            for (int i = 0; i < 20 && !valid_b; i++) tick();
            if (!valid_b) begin
                n_tests++;
                n_fail++;
                $display("FAIL rr_wait_b: got valid 0, expected grant %0d", g);
            end else begin
                ack_b = 1'b1;
                tick();
                ack_b = 1'b0;
            end
        end
        en_b  = 1'b0;
        req_b = '0;

        // Every queued grant must have been observed.
        for (int i = 0; i < 50; i++) begin
            if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() +
                exp_q[3].size() + exp_q[4].size() == 0) break;
            tick();
        end
        for (int d = 0; d < 5; d++) begin
            check($sformatf("drain_dut%0d", d), 64'(exp_q[d].size()), 64'd0);
        end

        // Async reset in HOLD.
        req_a = 8'h40;
        tick();
        req_a = 8'h00;
        req_a[7] = 1'b0;
        tick();
        check("pre_reset_valid", 64'(valid_a), 64'd1);
        check("pre_reset_idx",   64'(idx_a),   64'd6);
        req_a = 8'h02;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 64'(valid_a), 64'd0);
        check("async_reset_idx",   64'(idx_a),   64'd0);
        check("async_reset_pend",  64'(pend_a),  64'd0);
        tick();
        req_a = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
